// File: rtl/sd_host_bridge.sv
// Host packet sequencer in front of the SD interface block.
// Parses opcode/address/payload, drives SD strobes, returns data and status.
module sd_host_bridge #(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BUF_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       sd_read,
  output logic       sd_write,
  output logic       sd_addr_ready,
  output logic [7:0] sd_wdata,
  input  logic       sd_data_req,
  output logic       sd_fifo_rd,
  input  logic [7:0] sd_fifo_data,
  input  logic       sd_fifo_empty,
  input  logic       sd_done,
  input  logic       sd_err,
  output logic       busy
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int AWP = AW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [9:0]    LAST    = 10'(BLOCK_BYTES - 1);
  localparam logic [9:0]    FULLCNT = 10'(BLOCK_BYTES);
  localparam logic [AW:0]   DEPTH_C = AWP'(BUF_DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_RD = 8'h51;
  localparam logic [7:0] OP_WR = 8'h58;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_ISSUE = 4'd2;
  localparam logic [3:0] S_STRB  = 4'd3;
  localparam logic [3:0] S_WR    = 4'd4;
  localparam logic [3:0] S_DRAIN = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_WAIT  = 4'd7;
  localparam logic [3:0] S_STAT  = 4'd8;

  logic [3:0]    state, state_n;
  logic [7:0]    status, status_n;
  logic          is_wr;
  logic [31:0]   addr, addr_sh;
  logic [1:0]    idx;
  logic [9:0]    rx_cnt, pop_cnt, rd_iss;
  logic [7:0]    mem [BUF_DEPTH];
  logic [AW:0]   wp, rp;
  logic [TW-1:0] timer;
  logic          done_seen, rd_q, byte_v;
  logic [7:0]    byte_r;
  logic          rx_rdy, rx_fire, tx_fire;
  logic          buf_empty, buf_full, push, pop, underrun;
  logic          ev_ext, cnting, stall, tmo;

  assign buf_empty = wp == rp;
  assign buf_full  = (wp - rp) == DEPTH_C;
  assign addr_sh   = addr >> {~idx, 3'b000};

  assign rx_ready = rx_rdy & n_rst;
  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;
  assign push     = (state == S_WR) & rx_fire;
  assign pop      = (state == S_WR) & sd_data_req & !buf_empty;
  assign underrun = (state == S_WR) & sd_data_req & buf_empty;

  assign busy          = state != S_IDLE;
  assign sd_addr_ready = state == S_ISSUE;
  assign sd_read       = (state == S_STRB) & !is_wr;
  assign sd_write      = (state == S_STRB) & is_wr;

  // Host-side stalls freeze the SD watchdog
  assign ev_ext = sd_data_req | sd_done | sd_err;
  assign cnting = (state == S_WR) | (state == S_RD) | (state == S_WAIT);
  assign stall  = (state == S_RD) & tx_valid & !tx_ready;
  assign tmo    = cnting & !stall & !ev_ext & (timer == T_LAST);

  assign sd_fifo_rd = (state == S_RD) & !sd_fifo_empty
                    & (!tx_valid | tx_ready)
                    & (rd_iss != FULLCNT) & !sd_err & !tmo;

  always_comb begin
    rx_rdy   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    sd_wdata = '0;
    case (state)
      S_IDLE, S_ADDR: rx_rdy = 1'b1;
      S_ISSUE: sd_wdata = addr_sh[7:0];
      S_WR: begin
        rx_rdy   = !buf_full && (rx_cnt != FULLCNT);
        sd_wdata = mem[rp[AW-1:0]];
      end
      S_DRAIN: rx_rdy = rx_cnt != FULLCNT;
      S_RD: begin
        tx_valid = rd_q | byte_v;
        tx_data  = rd_q ? sd_fifo_data : byte_r;
      end
      S_STAT: begin
        tx_valid = 1'b1;
        tx_data  = status;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    status_n = status;
    case (state)
      S_IDLE:
        if (rx_fire) begin
          if ((rx_data == OP_RD) || (rx_data == OP_WR)) begin
            state_n = S_ADDR;
          end else begin
            state_n  = S_STAT;
            status_n = 8'hFF;
          end
        end
      S_ADDR:
        if (rx_fire && (idx == 2'd3)) state_n = S_ISSUE;
      S_ISSUE:
        if (idx == 2'd3) state_n = S_STRB;
      S_STRB:
        state_n = is_wr ? S_WR : S_RD;
      S_WR:
        if (sd_err) begin
          state_n  = S_DRAIN;
          status_n = 8'h01;
        end else if (underrun) begin
          state_n  = S_DRAIN;
          status_n = 8'h03;
        end else if (pop && (pop_cnt == LAST)) begin
          state_n = S_WAIT;
        end else if (tmo) begin
          state_n  = S_DRAIN;
          status_n = 8'h02;
        end
      S_DRAIN:
        if ((rx_cnt == FULLCNT) || (rx_fire && (rx_cnt == LAST)))
          state_n = S_STAT;
      S_RD:
        if (sd_err) begin
          state_n  = S_STAT;
          status_n = 8'h01;
        end else if (tx_fire && (pop_cnt == LAST)) begin
          state_n = S_WAIT;
        end else if (tmo) begin
          state_n  = S_STAT;
          status_n = 8'h02;
        end
      S_WAIT:
        if (sd_err) begin
          state_n  = S_STAT;
          status_n = 8'h01;
        end else if (sd_done || done_seen) begin
          state_n  = S_STAT;
          status_n = 8'h00;
        end else if (tmo) begin
          state_n  = S_STAT;
          status_n = 8'h02;
        end
      S_STAT:
        if (tx_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      status    <= '0;
      is_wr     <= 1'b0;
      addr      <= '0;
      idx       <= '0;
      rx_cnt    <= '0;
      pop_cnt   <= '0;
      rd_iss    <= '0;
      wp        <= '0;
      rp        <= '0;
      timer     <= '0;
      done_seen <= 1'b0;
      rd_q      <= 1'b0;
      byte_v    <= 1'b0;
      byte_r    <= '0;
    end else begin
      state  <= state_n;
      status <= status_n;
      if ((state_n != state) || ev_ext || sd_fifo_rd) timer <= '0;
      else if (cnting && !stall) timer <= timer + TW'(1);
      case (state)
        S_IDLE:
          if (rx_fire) begin
            is_wr <= rx_data == OP_WR;
            idx   <= '0;
          end
        S_ADDR:
          if (rx_fire) begin
            addr <= {addr[23:0], rx_data};
            idx  <= idx + 2'd1;
          end
        S_ISSUE: idx <= idx + 2'd1;
        S_STRB: begin
          rx_cnt    <= '0;
          pop_cnt   <= '0;
          rd_iss    <= '0;
          wp        <= '0;
          rp        <= '0;
          done_seen <= 1'b0;
          rd_q      <= 1'b0;
          byte_v    <= 1'b0;
        end
        S_WR: begin
          if (push) begin
            wp     <= wp + AWP'(1);
            rx_cnt <= rx_cnt + 10'd1;
          end
          if (pop) begin
            rp      <= rp + AWP'(1);
            pop_cnt <= pop_cnt + 10'd1;
          end
          if (sd_done) done_seen <= 1'b1;
        end
        S_DRAIN:
          if (rx_fire) rx_cnt <= rx_cnt + 10'd1;
        S_RD: begin
          if (sd_done) done_seen <= 1'b1;
          if (sd_fifo_rd) rd_iss <= rd_iss + 10'd1;
          if (tx_fire) pop_cnt <= pop_cnt + 10'd1;
          // FIFO data is only valid the cycle after the pop; hold it if stalled
          if (state_n != S_RD) begin
            rd_q   <= 1'b0;
            byte_v <= 1'b0;
          end else begin
            rd_q <= sd_fifo_rd;
            if (rd_q && !tx_ready) begin
              byte_r <= sd_fifo_data;
              byte_v <= 1'b1;
            end else if (tx_ready) begin
              byte_v <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
